// File: rtl/multi_input_conditioner_pkg.sv
// Shared constants for the input-conditioner family. The SPI top level uses
// these so that every conditioner instance agrees on its timing.
package multi_input_conditioner_pkg;

   // Flop depth of the synchroniser chain on each raw pin.
   localparam int DEFAULT_SYNC_STAGES = 2;

   // Extra consecutive stable cycles a new level must hold before it is accepted.
   localparam int DEFAULT_WAIT_TIME   = 3;

endpackage : multi_input_conditioner_pkg

// File: rtl/conditioner_channel.sv
// One conditioned input: a synchroniser chain, a debounce stability counter,
// and registered single-cycle rising/falling edge pulses.
module conditioner_channel
   import multi_input_conditioner_pkg::*;
#(
   parameter int   SYNC_STAGES = DEFAULT_SYNC_STAGES,
   parameter int   WAIT_TIME   = DEFAULT_WAIT_TIME,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic noisy,
   output logic conditioned,
   output logic pos_edge,
   output logic neg_edge,
   output logic pos_edge_next,
   output logic neg_edge_next
);

   localparam int               CNT_W    = $clog2(WAIT_TIME + 1);
   localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_TIME);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   cond_q, cond_d;
   logic                   pos_q, pos_d;
   logic                   neg_q, neg_d;
   logic                   s;

   // The synchronised level is the output of the last chain flop only.
   assign s = sync_q[SYNC_STAGES-1];

   // Next-state: shift the chain, then debounce the synchronised level.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
      sync_d = {sync_q[SYNC_STAGES-2:0], noisy};
      cond_d = cond_q;
      cnt_d  = '0;
      pos_d  = 1'b0;
      neg_d  = 1'b0;
      if (s != cond_q) begin
         if (cnt_q == WAIT_CNT) begin
            cond_d = s;
            pos_d  = s;
            neg_d  = ~s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // State registers; reset drops any debounce in progress.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking here so every flop samples the pre-edge values of the others.
      if (reset) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         cnt_q  <= '0;
         cond_q <= RESET_VAL;
         pos_q  <= 1'b0;
         neg_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         cond_q <= cond_d;
         pos_q  <= pos_d;
         neg_q  <= neg_d;
      end
   end

   assign conditioned   = cond_q;
   assign pos_edge      = pos_q;
   assign neg_edge      = neg_q;
   assign pos_edge_next = pos_d;
   assign neg_edge_next = neg_d;

endmodule : conditioner_channel

// File: rtl/multi_input_conditioner.sv
// N independent conditioned inputs in one clock domain, plus a registered
// "any edge this cycle" flag aligned with the per-channel edge pulses.
module multi_input_conditioner
   import multi_input_conditioner_pkg::*;
#(
   parameter int                  CHANNELS    = 4,
   parameter int                  SYNC_STAGES = DEFAULT_SYNC_STAGES,
   parameter int                  WAIT_TIME   = DEFAULT_WAIT_TIME,
   parameter logic [CHANNELS-1:0] RESET_LEVEL = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] noisysignal,
   output logic [CHANNELS-1:0] conditioned,
   output logic [CHANNELS-1:0] positiveedge,
   output logic [CHANNELS-1:0] negativeedge,
   output logic                anyedge
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("multi_input_conditioner: SYNC_STAGES must be >= 2");
   end
   if (WAIT_TIME < 1) begin : g_bad_wait
      $error("multi_input_conditioner: WAIT_TIME must be >= 1");
   end

   logic [CHANNELS-1:0] pos_next;
   logic [CHANNELS-1:0] neg_next;
   logic                anyedge_q, anyedge_d;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      conditioner_channel #(
         .SYNC_STAGES (SYNC_STAGES),
         .WAIT_TIME   (WAIT_TIME),
         .RESET_VAL   (RESET_LEVEL[i])
      ) u_ch (
         .clk           (clk),
         .reset         (reset),
         .noisy         (noisysignal[i]),
         .conditioned   (conditioned[i]),
         .pos_edge      (positiveedge[i]),
         .neg_edge      (negativeedge[i]),
         .pos_edge_next (pos_next[i]),
         .neg_edge_next (neg_next[i])
      );
   end

   // Built from next-state edges so the flag lands in the same cycle as the pulses.
   always_comb begin
      anyedge_d = |(pos_next | neg_next);
   end

   // Register the combined edge flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) anyedge_q <= 1'b0;
      else       anyedge_q <= anyedge_d;
   end

   assign anyedge = anyedge_q;

endmodule : multi_input_conditioner

// File: tb/tb_multi_input_conditioner.sv
// Self-checking bench: directed scenarios plus randomized stimulus, all
// compared cycle by cycle against a behavioural reference model.
module tb_multi_input_conditioner;

   localparam int         CH    = 4;
   localparam int         SYNC  = 2;
   localparam int         WAIT  = 3;
   localparam logic [3:0] RLVL  = 4'b1000;

   logic          clk = 1'b0;
   logic          reset;
   logic [CH-1:0] noisysignal;
   logic [CH-1:0] conditioned, positiveedge, negativeedge;
   logic          anyedge;

   int checks   = 0;
   int failures = 0;

   multi_input_conditioner #(
      .CHANNELS    (CH),
      .SYNC_STAGES (SYNC),
      .WAIT_TIME   (WAIT),
      .RESET_LEVEL (RLVL)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .noisysignal  (noisysignal),
      .conditioned  (conditioned),
      .positiveedge (positiveedge),
      .negativeedge (negativeedge),
      .anyedge      (anyedge)
   );

   always #5 clk = ~clk;

   // Reference model: the pin value seen by the debouncer is the value sampled
   // SYNC edges earlier; a level is accepted once it has differed from the
   // output for WAIT+1 consecutive edges.
   logic [CH-1:0] delay_line[$];
   int            run_len[CH];
   logic [CH-1:0] m_cond, m_pos, m_neg;
   logic          m_any;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      delay_line.delete();
      for (int i = 0; i < SYNC; i++) delay_line.push_back(RLVL);
      for (int c = 0; c < CH; c++) run_len[c] = 0;
      m_cond = RLVL;
      m_pos  = '0;
      m_neg  = '0;
      m_any  = 1'b0;
   endtask

   task automatic model_edge(input logic [CH-1:0] din);
      logic [CH-1:0] s;
      s = delay_line.pop_front();
      delay_line.push_back(din);
      m_pos = '0;
      m_neg = '0;
      for (int c = 0; c < CH; c++) begin
         if (s[c] == m_cond[c]) begin
            run_len[c] = 0;
         end else begin
            run_len[c]++;
            if (run_len[c] == WAIT + 1) begin
               m_cond[c]  = s[c];
               m_pos[c]   = s[c];
               m_neg[c]   = ~s[c];
               run_len[c] = 0;
            end
         end
      end
      m_any = |(m_pos | m_neg);
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".cond"}, 32'(conditioned),  32'(m_cond));
      check({tag, ".pos"},  32'(positiveedge), 32'(m_pos));
      check({tag, ".neg"},  32'(negativeedge), 32'(m_neg));
      check({tag, ".any"},  32'(anyedge),      32'(m_any));
   endtask

   // One clock: drive din, take the edge, then compare 1 time unit later.
   task automatic cycle(input logic [CH-1:0] din, input string tag);
      noisysignal = din;
      @(posedge clk);
      if (!reset) model_edge(din);
      #1;
      compare_all(tag);
   endtask

   task automatic hold(input logic [CH-1:0] din, input int n, input string tag);
      for (int k = 0; k < n; k++) cycle(din, tag);
   endtask

   task automatic assert_reset();
      reset = 1'b1;
      model_reset();
      #1;
      compare_all("rst_async");
   endtask

   task automatic release_reset();
      reset = 1'b0;
   endtask

   int cnt;
   logic [CH-1:0] cur;

   initial begin
      reset       = 1'b1;
      noisysignal = 4'b0101;
      model_reset();

      // 1: reset state, then release with a stable pattern.
      #2;
      check("t1_rst_cond", 32'(conditioned), 32'(4'b1000));
      check("t1_rst_edges", 32'({positiveedge, negativeedge, anyedge}), 32'd0);
      hold(4'b0101, 3, "t1_in_rst");
      release_reset();
      for (int k = 1; k <= 8; k++) begin
         cycle(4'b0101, "t1");
         if (k == 5) check("t1_e5_cond", 32'(conditioned), 32'(4'b1000));
         if (k == 6) begin
            check("t1_e6_pos", 32'(positiveedge), 32'(4'b0101));
            check("t1_e6_neg", 32'(negativeedge), 32'(4'b1000));
            check("t1_e6_any", 32'(anyedge), 32'd1);
         end
         if (k == 7) check("t1_e7_any", 32'(anyedge), 32'd0);
      end

      // 2: clean rise then fall on ch1.
      for (int k = 1; k <= 8; k++) begin
         cycle(4'b0111, "t2r");
         if (k == 6) check("t2_rise_pos", 32'(positiveedge), 32'(4'b0010));
         if (k == 7) check("t2_rise_pos_off", 32'(positiveedge), 32'd0);
      end
      for (int k = 1; k <= 8; k++) begin
         cycle(4'b0101, "t2f");
         if (k == 6) check("t2_fall_neg", 32'(negativeedge), 32'(4'b0010));
      end

      // 3: glitch boundary on ch2 (bring it low first).
      hold(4'b0001, 10, "t3_pre");
      hold(4'b0101, 3, "t3_g3");
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         cycle(4'b0001, "t3_g3_after");
         cnt += int'(positiveedge[2]);
      end
      check("t3_g3_no_pulse", 32'(cnt), 32'd0);
      check("t3_g3_cond", 32'(conditioned[2]), 32'd0);
      for (int k = 1; k <= 8; k++) begin
         cycle((k <= 4) ? 4'b0101 : 4'b0001, "t3_g4");
         if (k == 6) check("t3_g4_pos", 32'(positiveedge), 32'(4'b0100));
      end
      hold(4'b0001, 8, "t3_post");

      // 4: simultaneous opposite events on ch0 and ch1.
      hold(4'b0010, 12, "t4_pre");
      for (int k = 1; k <= 7; k++) begin
         cycle(4'b0001, "t4");
         if (k == 6) begin
            check("t4_pos", 32'(positiveedge), 32'(4'b0001));
            check("t4_neg", 32'(negativeedge), 32'(4'b0010));
            check("t4_any", 32'(anyedge), 32'd1);
         end
         if (k == 7) check("t4_any_off", 32'(anyedge), 32'd0);
      end

      // 5: reset in the middle of a ch0 debounce.
      hold(4'b0000, 12, "t5_pre");
      hold(4'b0001, 4, "t5_mid");
      assert_reset();
      check("t5_rst_cond0", 32'(conditioned[0]), 32'd0);
      hold(4'b0001, 2, "t5_in_rst");
      release_reset();
      cnt = 0;
      for (int k = 1; k <= 10; k++) begin
         cycle(4'b0001, "t5");
         if (k == 5) check("t5_e5_cond0", 32'(conditioned[0]), 32'd0);
         if (k == 6) check("t5_e6_cond0", 32'(conditioned[0]), 32'd1);
         cnt += int'(positiveedge[0]);
      end
      check("t5_one_pulse", 32'(cnt), 32'd1);

      // 6: chatter on ch3, then settle high.
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         cur = {~k[0], 3'b001};
         cycle(cur, "t6_chat");
         cnt += int'(positiveedge[3] | negativeedge[3]);
      end
      check("t6_chatter_quiet", 32'(cnt), 32'd0);
      cnt = 0;
      for (int k = 1; k <= 10; k++) begin
         cycle(4'b1001, "t6_settle");
         if (k == 6) check("t6_pos3", 32'(positiveedge[3]), 32'd1);
         cnt += int'(positiveedge[3]);
      end
      check("t6_one_pulse", 32'(cnt), 32'd1);

      // 7: randomized inputs with sparse flips and occasional resets.
      cur = 4'b1001;
      for (int k = 0; k < 600; k++) begin
         for (int c = 0; c < CH; c++)
            if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
         if ($urandom_range(0, 149) == 0) begin
            assert_reset();
            hold(cur, int'($urandom_range(1, 2)), "rnd_rst");
            release_reset();
         end
         cycle(cur, "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_multi_input_conditioner

// File: doc/multi_input_conditioner.md
Name: multi_input_conditioner

Overview:
Parametrised N-channel input conditioner. It is the next generation of the single-pin inputconditioner. Each channel:
- synchronises an asynchronous noisy input through a configurable-depth flop chain;
- debounces it with a per-channel stability counter;
- emits registered single-cycle rising and falling edge pulses.

It sits between the SPI pins (sclk, cs, mosi, buttons) and the protocol FSMs. All channels share one clock domain.

Parameters:
CHANNELS, 4, number of independent input channels
SYNC_STAGES, 2, synchroniser flop depth (legal: >= 2)
WAIT_TIME, 3, extra consecutive stable cycles required before conditioned output changes (legal: >= 1)
RESET_LEVEL, {CHANNELS{1'b0}}, per-channel reset value of synchroniser, conditioned output and edge history

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
noisysignal  input  CHANNELS  raw asynchronous inputs, bit i = channel i
conditioned  output  CHANNELS  synchronised, debounced level
positiveedge  output  CHANNELS  one-cycle pulse when conditioned[i] goes 0->1
negativeedge  output  CHANNELS  one-cycle pulse when conditioned[i] goes 1->0
anyedge  output  1  registered OR of all positiveedge|negativeedge bits for the same cycle

Behaviour:
- Clocking: one clock (clk). Reset is asynchronous and active-high (reset); it clears all state immediately, independent of clk.
- Reset values, per channel i:
  - sync chain = RESET_LEVEL[i]
  - conditioned[i] = RESET_LEVEL[i]
  - counter = 0
  - positiveedge[i] = 0, negativeedge[i] = 0, anyedge = 0
- Synchroniser: s[i] is the output of the last of SYNC_STAGES flops. No logic sits between the stages.
- Debounce counter: width is clog2(WAIT_TIME+1), derived locally. On each clk edge, per channel:
  - s == conditioned: counter <= 0; edge outputs <= 0.
  - s != conditioned and counter == WAIT_TIME: conditioned <= s; counter <= 0; positiveedge <= s; negativeedge <= !s.
  - s != conditioned and counter < WAIT_TIME: counter <= counter + 1; edge outputs <= 0.
- Latency: for a clean change held stable, conditioned changes on rising edge number SYNC_STAGES+WAIT_TIME+1 after the change. Edge 1 is the first rising edge sampling the new value. Defaults give 6.
- Edge pulses: asserted in the same cycle conditioned changes, exactly one cycle wide. positiveedge[i] and negativeedge[i] are never both high.
- anyedge: registered OR-reduction of the next-state edge vectors, aligned with the edge outputs (not delayed). Back-to-back pulses on different channels keep anyedge high continuously.
- Glitch rejection:
  - After synchronisation, a disagreement lasting <= WAIT_TIME cycles is ignored; the counter returns to 0 when s re-agrees.
  - A disagreement lasting WAIT_TIME+1 cycles is accepted.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- Reset mid-debounce: counter is discarded. After release, the full latency applies again from the first sampled edge.
- Elaboration: $error if SYNC_STAGES < 2 or WAIT_TIME < 1.

Decomposition:
- Shared header: default constants (DEFAULT_SYNC_STAGES, DEFAULT_WAIT_TIME) for use by the SPI top level. No typedefs are needed.
- Sub-module conditioner_channel (1-bit sync chain, counter, edge registers), parametrised by SYNC_STAGES, WAIT_TIME and a scalar RESET_VAL.
- multi_input_conditioner instantiates CHANNELS copies in a generate loop and builds anyedge.

Test Plan:
1. Reset check, defaults, CHANNELS=4, RESET_LEVEL=4'b1000. Hold reset with noisysignal=4'b0101, then release while input is stable.
   -> During reset: conditioned=4'b1000, all edge outputs 0.
   -> After release: ch0/ch2 rise and ch3 falls, all at edge 6. positiveedge=4'b0101, negativeedge=4'b1000 and anyedge=1 for exactly that one cycle.
2. Clean rise: ch1 0->1 held high.
   -> conditioned[1] rises at edge 6; positiveedge[1]=1 for one cycle only; other channels show no activity.
   -> Then 1->0: negativeedge[1] pulses at edge 6.
3. Glitch boundary, ch2:
   - high pulse 3 cycles long -> no change, no pulses;
   - high pulse 4 cycles long -> conditioned[2]=1 and positiveedge[2] pulses at edge 6 after the pulse start.
4. Simultaneous events: ch0 rises while ch1 falls on the same cycle.
   -> positiveedge=4'b0001 and negativeedge=4'b0010 in the same cycle; anyedge high for one cycle.
5. Reset mid-operation: ch0 rises; assert reset after edge 4 (counter=2); release with input still high.
   -> conditioned[0]=0 during reset; it rises at edge 6 after release; exactly one positiveedge.
6. Chatter: ch3 toggles every cycle for 20 cycles, then settles high.
   -> No pulses during chatter; a single positiveedge[3] at edge 6 after settling.
